imem_arbiter: RTL and testbench

Shares one single-ported instruction/data memory between the fetch stage's instruction port and the load/store unit's data port. Sits between the core and the memory. Selects one requester per transaction and forwards its request to memory. Routes the memory response back to the owner and drops a stale fetch response after a taken jump. At most one transaction is outstanding.

---
 rtl/imem_arbiter.sv | 144 ++++++++++++++
 tb/tb_imem_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Arbitrates one single-ported memory between the fetch port and the load/store data port.
// Optional starvation guard for fetch: define IMEM_ARB_STARVE_GUARD_EN.
module imem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [31:0] f_addr,
  output logic        f_gnt,
  output logic        f_rvalid,
  output logic [31:0] f_rdata,
  input  logic        f_flush,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic        m_gnt,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic [1:0]  state_dbg
);

  // Handshake: each requester holds req and its fields stable until its gnt;
  // gnt = selected & m_gnt in the same cycle; every grant yields exactly one m_rvalid.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_F = 2'd1,
    BUSY_D = 2'd2,
    DROP   = 2'd3
  } state_t;

  state_t state, state_nxt;
  logic   sel_ok, sel_d, sel_f;
  logic   starve_force;

`ifdef IMEM_ARB_STARVE_GUARD_EN
  logic [2:0] starve_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 3'd0;
    end else if (!f_req || f_gnt) begin
      starve_cnt <= 3'd0;
    end else if (d_gnt && starve_cnt != 3'd7) begin
      starve_cnt <= starve_cnt + 3'd1;
    end
  end

  assign starve_force = f_req && (int'(starve_cnt) >= STARVE_MAX);
`else
  logic [31:0] unused_starve_max;
  assign unused_starve_max = STARVE_MAX;
  assign starve_force      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    sel_ok    = 1'b0;
    sel_d     = 1'b0;
    sel_f     = 1'b0;
    f_gnt     = 1'b0;
    d_gnt     = 1'b0;
    f_rvalid  = 1'b0;
    f_rdata   = 32'd0;
    d_rvalid  = 1'b0;
    d_rdata   = 32'd0;
    m_req     = 1'b0;
    m_we      = 1'b0;
    m_addr    = 32'd0;
    m_wdata   = 32'd0;
    m_be      = 4'd0;

    // Outputs are held quiet for the whole time reset is asserted.
    if (!rst) begin
      case (state)
        IDLE: sel_ok = 1'b1;
        BUSY_F: begin
          if (m_rvalid) begin
            sel_ok    = 1'b1;
            state_nxt = IDLE;
            if (!f_flush) begin
              f_rvalid = 1'b1;
              f_rdata  = m_rdata;
            end
          end else if (f_flush) begin
            state_nxt = DROP;
          end
        end
        BUSY_D: begin
          if (m_rvalid) begin
            sel_ok    = 1'b1;
            state_nxt = IDLE;
            d_rvalid  = 1'b1;
            d_rdata   = m_rdata;
          end
        end
        DROP: begin
          if (m_rvalid) begin
            sel_ok    = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase

      if (sel_ok) begin
        sel_d = d_req && !starve_force;
        sel_f = !sel_d && f_req;
        m_req = sel_d || sel_f;
        if (sel_d) begin
          m_we    = d_we;
          m_addr  = d_addr;
          m_wdata = d_wdata;
          m_be    = d_be;
        end else if (sel_f) begin
          m_addr = f_addr;
          m_be   = 4'hF;
        end
        d_gnt = sel_d && m_gnt;
        f_gnt = sel_f && m_gnt;
        if (d_gnt) state_nxt = BUSY_D;
        if (f_gnt) state_nxt = BUSY_F;
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: per-cycle vector table plus hand sequences
// for reset and fetch starvation.
module tb_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, f_flush, d_req, d_we, m_gnt, m_rvalid;
  logic [31:0] f_addr, d_addr, d_wdata, m_rdata;
  logic [3:0]  d_be;
  logic        f_gnt, f_rvalid, d_gnt, d_rvalid, m_req, m_we;
  logic [31:0] f_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_be;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        fr;
    logic [31:0] fa;
    logic        ff;
    logic        dr;
    logic        dw;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dbe;
    logic        mg;
    logic        mv;
    logic [31:0] mrd;
    logic [5:0]  e_ctl;   // {f_gnt,d_gnt,f_rvalid,d_rvalid,m_req,m_we}
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_frd;
    logic [31:0] e_drd;
    logic [1:0]  e_state;
  } vec_t;

  vec_t        vecs[$];
  logic [1:0]  exp_q[$];

  imem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_flush(f_flush),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [5:0] ctl();
    return {f_gnt, d_gnt, f_rvalid, d_rvalid, m_req, m_we};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    f_req = 0; f_addr = 0; f_flush = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    m_gnt = 0; m_rvalid = 0; m_rdata = 0;
  endtask

  task automatic add(input logic fr, input logic [31:0] fa, input logic ff,
                     input logic dr, input logic dw, input logic [31:0] da,
                     input logic [31:0] dwd, input logic [3:0] dbe,
                     input logic mg, input logic mv, input logic [31:0] mrd,
                     input logic [5:0] ectl, input logic [31:0] eaddr, input logic [3:0] ebe,
                     input logic [31:0] efrd, input logic [31:0] edrd, input logic [1:0] est);
    vec_t v;
    v.fr = fr; v.fa = fa; v.ff = ff; v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.dbe = dbe; v.mg = mg; v.mv = mv; v.mrd = mrd; v.e_ctl = ectl; v.e_addr = eaddr;
    v.e_be = ebe; v.e_frd = efrd; v.e_drd = edrd; v.e_state = est;
    vecs.push_back(v);
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(posedge clk);
    #1;
    f_req = v.fr; f_addr = v.fa; f_flush = v.ff;
    d_req = v.dr; d_we = v.dw; d_addr = v.da; d_wdata = v.dwd; d_be = v.dbe;
    m_gnt = v.mg; m_rvalid = v.mv; m_rdata = v.mrd;
    #1;
    chk($sformatf("v%0d state", idx), 64'(state_dbg), 64'(v.e_state));
    chk($sformatf("v%0d ctl", idx), 64'(ctl()), 64'(v.e_ctl));
    chk($sformatf("v%0d f_rdata", idx), 64'(f_rdata), 64'(v.e_frd));
    chk($sformatf("v%0d d_rdata", idx), 64'(d_rdata), 64'(v.e_drd));
    if (v.e_ctl[1]) begin
      chk($sformatf("v%0d m_addr", idx), 64'(m_addr), 64'(v.e_addr));
      chk($sformatf("v%0d m_be", idx), 64'(m_be), 64'(v.e_be));
    end
  endtask

  initial begin
    int n_fetch;
    logic [1:0] exp_g;

    // reset with requests pending: everything must stay quiet
    rst = 1'b1;
    idle_inputs();
    f_req = 1; d_req = 1; m_gnt = 1; m_rvalid = 1; m_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #2;
    chk("reset ctl", 64'(ctl()), 64'd0);
    chk("reset rdata", {f_rdata, d_rdata}, 64'd0);
    chk("reset state", 64'(state_dbg), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();

    // fr fa ff | dr dw da dwd dbe | mg mv mrd || ctl addr be frd drd state
    // single fetch, latency 1, then stray m_rvalid in IDLE
    add(1, 'h100, 0, 0, 0, 0, 0, 0, 1, 0, 0,            6'b100010, 'h100, 'hF, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hDEADBEEF,       6'b001000, 0, 0, 'hDEADBEEF, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h12345678,       6'b000000, 0, 0, 0, 0, 0);
    // contention: data write wins, fetch granted in the ack cycle
    add(1, 'h104, 0, 1, 1, 'h2000, 'hCAFEF00D, 'h3, 1, 0, 0, 6'b010011, 'h2000, 'h3, 0, 0, 0);
    add(1, 'h104, 0, 0, 0, 0, 0, 0, 1, 1, 'h55,         6'b100110, 'h104, 'hF, 0, 'h55, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h11112222,       6'b001000, 0, 0, 'h11112222, 0, 1);
    // memory stalls the grant, then a 2-cycle read
    add(0, 0, 0, 1, 0, 'h3000, 0, 'hF, 0, 0, 0,         6'b000010, 'h3000, 'hF, 0, 0, 0);
    add(0, 0, 0, 1, 0, 'h3000, 0, 'hF, 1, 0, 0,         6'b010010, 'h3000, 'hF, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                6'b000000, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'hA5A5A5A5,       6'b000100, 0, 0, 0, 'hA5A5A5A5, 2);
    // flush before response -> DROP, queued data granted in the discard cycle
    add(1, 'h200, 0, 0, 0, 0, 0, 0, 1, 0, 0,            6'b100010, 'h200, 'hF, 0, 0, 0);
    add(0, 0, 1, 1, 0, 'h3004, 0, 'hF, 1, 0, 0,         6'b000000, 0, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 'h3004, 0, 'hF, 1, 1, 'hBAD0BAD0, 6'b010010, 'h3004, 'hF, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h77,             6'b000100, 0, 0, 0, 'h77, 2);
    // flush with response: dropped, new fetch granted same cycle is kept
    add(1, 'h300, 0, 0, 0, 0, 0, 0, 1, 0, 0,            6'b100010, 'h300, 'hF, 0, 0, 0);
    add(1, 'h400, 1, 0, 0, 0, 0, 0, 1, 1, 'h99,         6'b100010, 'h400, 'hF, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h400400,         6'b001000, 0, 0, 'h400400, 0, 1);
    // flush in BUSY_D and IDLE has no effect
    add(0, 0, 0, 1, 0, 'h3008, 0, 'hC, 1, 0, 0,         6'b010010, 'h3008, 'hC, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 'h88,             6'b000100, 0, 0, 0, 'h88, 2);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,                6'b000000, 0, 0, 0, 0, 0);
    // back-to-back fetches
    add(1, 'h500, 0, 0, 0, 0, 0, 0, 1, 0, 0,            6'b100010, 'h500, 'hF, 0, 0, 0);
    add(1, 'h504, 0, 0, 0, 0, 0, 0, 1, 1, 'h500,        6'b101010, 'h504, 'hF, 'h500, 0, 1);
    add(1, 'h508, 0, 0, 0, 0, 0, 0, 1, 1, 'h504,        6'b101010, 'h508, 'hF, 'h504, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h508,            6'b001000, 0, 0, 'h508, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,                6'b000000, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // starvation: both requesters held, memory latency 1
    for (int i = 0; i < 20; i++) begin
`ifdef IMEM_ARB_STARVE_GUARD_EN
      exp_q.push_back((i % 5 == 4) ? 2'b10 : 2'b01);
`else
      exp_q.push_back(2'b01);
`endif
    end
    n_fetch = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      idle_inputs();
      f_req = 1; f_addr = 'h600; d_req = 1; d_addr = 'h4000; d_be = 'hF;
      m_gnt = 1; m_rvalid = (i > 0); m_rdata = 32'(i);
      #1;
      exp_g = exp_q.pop_front();
      chk($sformatf("starve grant %0d", i), 64'({f_gnt, d_gnt}), 64'(exp_g));
      if (f_gnt) n_fetch++;
    end
`ifdef IMEM_ARB_STARVE_GUARD_EN
    chk("starve fetch count", 64'(n_fetch), 64'd4);
`else
    chk("starve fetch count", 64'(n_fetch), 64'd0);
`endif
    @(posedge clk);
    #1;
    idle_inputs();
    m_rvalid = 1;
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
    chk("post-starve state", 64'(state_dbg), 64'd0);

    // reset while a data write is outstanding
    @(posedge clk);
    #1;
    d_req = 1; d_we = 1; d_addr = 'h3010; d_wdata = 'h0BADF00D; d_be = 'hF; m_gnt = 1;
    #1;
    chk("rst-seq grant", 64'(ctl()), 64'b010011);
    chk("rst-seq m_wdata", 64'(m_wdata), 64'h0BADF00D);
    @(posedge clk);
    #1;
    f_req = 1; f_addr = 'h700; m_rvalid = 1; m_rdata = 'h5A5A;
    #1;
    chk("rst-seq busy_d", 64'(state_dbg), 64'd2);
    rst = 1'b1;
    #1;
    chk("rst-seq async ctl", 64'(ctl()), 64'd0);
    chk("rst-seq async rdata", {f_rdata, d_rdata}, 64'd0);
    chk("rst-seq async state", 64'(state_dbg), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1;
    m_rvalid = 1; m_rdata = 'hFEEDFACE;
    #1;
    chk("rst-seq late rvalid", 64'(ctl()), 64'd0);
    chk("rst-seq late rdata", {f_rdata, d_rdata}, 64'd0);
    @(posedge clk);
    #1;
    idle_inputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
